// File: rtl/iter_shifter.sv
// iter_shifter: multi-cycle shifter that moves the operand one bit per clock.
// An operand, op code and amount are accepted over a valid/ready handshake,
// the result is returned over a second valid/ready handshake.
// Optional feature macro: ROTATE_EN compiles in ROL/ROR. Without it, those
// op codes take the zero-cycle pass path.
//
// state | meaning
// IDLE  | ready for a request, in_ready=1
// SHIFT | one-bit step per clock until the down-counter reaches zero
// DONE  | result held on sout, out_valid=1, waits for out_ready
module iter_shifter #(
   parameter int WIDTH = 16,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in,
   input  logic [2:0]       shift,
   input  logic [AMT_W-1:0] amt,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sout
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_SHIFT = 2'd1;
   localparam logic [1:0] S_DONE  = 2'd2;

   localparam logic [2:0] OP_LSL = 3'b001;
   localparam logic [2:0] OP_LSR = 3'b010;
   localparam logic [2:0] OP_ASR = 3'b011;
   localparam logic [2:0] OP_ROL = 3'b100;
   localparam logic [2:0] OP_ROR = 3'b101;

   logic [1:0]       state;
   logic [2:0]       op;
   logic [AMT_W-1:0] cnt;
   logic [WIDTH-1:0] work;
   logic [WIDTH-1:0] step;
   logic             op_moves;

   // Does the incoming op code move bits at all (pass/reserved do not)
   always_comb begin
      op_moves = 1'b0;
      case (shift)
         OP_LSL, OP_LSR, OP_ASR: op_moves = 1'b1;
`ifdef ROTATE_EN
         OP_ROL, OP_ROR:         op_moves = 1'b1;
`endif
         default:                op_moves = 1'b0;
      endcase
   end

   // One-bit step of the work register for the latched op
   always_comb begin
      step = work;
      case (op)
         OP_LSL: step = {work[WIDTH-2:0], 1'b0};
         OP_LSR: step = {1'b0, work[WIDTH-1:1]};
         OP_ASR: step = {work[WIDTH-1], work[WIDTH-1:1]};
`ifdef ROTATE_EN
         OP_ROL: step = {work[WIDTH-2:0], work[WIDTH-1]};
         OP_ROR: step = {work[0], work[WIDTH-1:1]};
`endif
         default: step = work;
      endcase
   end

   // Sequencer: accept, step down the counter, hold result until consumed
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= S_IDLE;
         op    <= 3'b000;
         cnt   <= '0;
         work  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (in_valid) begin
                  work  <= in;
                  op    <= shift;
                  cnt   <= amt;
                  state <= (op_moves && (amt != '0)) ? S_SHIFT : S_DONE;
               end
            end
            S_SHIFT: begin
               work <= step;
               cnt  <= cnt - AMT_W'(1);
               if (cnt == AMT_W'(1)) begin
                  state <= S_DONE;
               end
            end
            S_DONE: begin
               // a pending request is deliberately not looked at here
               if (out_ready) begin
                  state <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign in_ready  = (state == S_IDLE);
   assign out_valid = (state == S_DONE);
   assign sout      = work;

endmodule
